// File: rtl/response_checker.sv
// response_checker: golden-response comparator for single-fault simulation.
// Accepts circuit-under-test response vectors over a valid/ready handshake,
// compares each against an expected vector from a synchronous ROM, and
// accumulates mismatch statistics for the run.
module response_checker #(
  parameter int unsigned OUTPUT_WIDTH    = 7,
  parameter int unsigned NUMBER_OF_TESTS = 10000,
  parameter int unsigned INDEX_WIDTH     = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  input  logic [OUTPUT_WIDTH-1:0] resp_data,
  output logic [INDEX_WIDTH-1:0]  exp_addr,
  input  logic [OUTPUT_WIDTH-1:0] exp_data,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [INDEX_WIDTH-1:0]  mismatch_count,
  output logic [INDEX_WIDTH-1:0]  first_fail_index,
  output logic [OUTPUT_WIDTH-1:0] first_fail_diff,
  output logic [OUTPUT_WIDTH-1:0] detect_mask
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUMBER_OF_TESTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_COMPARE,
    ST_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [INDEX_WIDTH-1:0]  index;
  logic [OUTPUT_WIDTH-1:0] expected;
  logic                    expected_loaded;

  logic                    xfer;
  logic                    launch;
  logic [OUTPUT_WIDTH-1:0] cmp_exp;
  logic [OUTPUT_WIDTH-1:0] diff;
  logic                    diff_nz;
  logic [INDEX_WIDTH-1:0]  count_nxt;

  // The ROM is addressed by the running index at all times; it only matters
  // during FETCH and COMPARE, and reads back 0 after reset.
  assign exp_addr   = index;
  assign resp_ready = (state == ST_COMPARE);
  assign busy       = (state == ST_FETCH) || (state == ST_COMPARE);
  assign done       = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured when no run is in progress.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_COMPARE;
      ST_COMPARE: begin
        if (xfer) begin
          state_nxt = (index == LAST_INDEX) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:    if (start) state_nxt = ST_FETCH;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Compare path. The ROM word arrives during the first COMPARE cycle, so
  // that cycle compares against exp_data directly while it is captured into
  // the expected register; any later waiting cycles use the register.
  always_comb begin
    launch    = start && ((state == ST_IDLE) || (state == ST_DONE));
    xfer      = (state == ST_COMPARE) && resp_valid;
    cmp_exp   = expected_loaded ? expected : exp_data;
    diff      = resp_data ^ cmp_exp;
    diff_nz   = |diff;
    count_nxt = mismatch_count;
    if (diff_nz && (mismatch_count != '1)) begin
      count_nxt = mismatch_count + INDEX_WIDTH'(1);
    end
  end

  // Index, expected register and run statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index            <= '0;
      expected         <= '0;
      expected_loaded  <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_index <= '1;
      first_fail_diff  <= '0;
      detect_mask      <= '0;
    end else if (launch) begin
      index            <= '0;
      expected_loaded  <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_index <= '1;
      first_fail_diff  <= '0;
      detect_mask      <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          expected_loaded <= 1'b0;
        end
        ST_COMPARE: begin
          if (!expected_loaded) begin
            expected        <= exp_data;
            expected_loaded <= 1'b1;
          end
          if (xfer) begin
            expected_loaded <= 1'b0;
            mismatch_count  <= count_nxt;
            detect_mask     <= detect_mask | diff;
            // The count only leaves zero on a mismatch and saturates rather
            // than wrapping, so zero identifies the first failure.
            if (diff_nz && (mismatch_count == '0)) begin
              first_fail_index <= index;
              first_fail_diff  <= diff;
            end
            if (index == LAST_INDEX) begin
              pass <= (count_nxt == '0);
            end else begin
              index <= index + INDEX_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_checker.sv
// Self-checking bench for response_checker: directed scenarios plus
// randomized runs scored against a per-run reference computed from arrays.
module tb_response_checker;

  localparam int W  = 7;
  localparam int NT = 4;
  localparam int IW = 14;
  localparam int PERIOD = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic [IW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [IW-1:0] mismatch_count;
  logic [IW-1:0] first_fail_index;
  logic [W-1:0]  first_fail_diff;
  logic [W-1:0]  detect_mask;

  always #(PERIOD/2) clk = ~clk;

  response_checker #(
    .OUTPUT_WIDTH(W),
    .NUMBER_OF_TESTS(NT),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .exp_addr(exp_addr),
    .exp_data(exp_data),
    .busy(busy),
    .done(done),
    .pass(pass),
    .mismatch_count(mismatch_count),
    .first_fail_index(first_fail_index),
    .first_fail_diff(first_fail_diff),
    .detect_mask(detect_mask)
  );

  // Golden ROM and response vectors for the current run.
  logic [W-1:0] rom  [NT];
  logic [W-1:0] resp [NT];

  // Synchronous ROM: data valid one cycle after the address.
  always_ff @(posedge clk) begin
    exp_data <= (exp_addr < IW'(NT)) ? rom[exp_addr[1:0]] : '0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results for one run, straight from the arrays.
  int           m_count;
  int           m_ffi;
  logic [W-1:0] m_ffd;
  logic [W-1:0] m_mask;

  task automatic model_run();
    logic [W-1:0] d;
    m_count = 0;
    m_ffi   = (1 << IW) - 1;
    m_ffd   = '0;
    m_mask  = '0;
    for (int i = 0; i < NT; i++) begin
      d = resp[i] ^ rom[i];
      if (d != 0) begin
        if (m_count == 0) begin
          m_ffi = i;
          m_ffd = d;
        end
        m_count++;
      end
      m_mask = m_mask | d;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".done"},  32'(done), 32'd1);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".pass"},  32'(pass), 32'(m_count == 0));
    check({tag, ".count"}, 32'(mismatch_count), 32'(m_count));
    check({tag, ".ffi"},   32'(first_fail_index), 32'(m_ffi));
    check({tag, ".ffd"},   32'(first_fail_diff), 32'(m_ffd));
    check({tag, ".mask"},  32'(detect_mask), 32'(m_mask));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ready"}, 32'(resp_ready), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".done"},  32'(done), 32'd0);
    check({tag, ".pass"},  32'(pass), 32'd0);
    check({tag, ".addr"},  32'(exp_addr), 32'd0);
    check({tag, ".count"}, 32'(mismatch_count), 32'd0);
    check({tag, ".ffi"},   32'(first_fail_index), 32'((1 << IW) - 1));
    check({tag, ".ffd"},   32'(first_fail_diff), 32'd0);
    check({tag, ".mask"},  32'(detect_mask), 32'd0);
  endtask

  // Offer one response after a random gap; returns at the negedge after the
  // transfer. Once ready is seen during the gap it must stay high.
  task automatic send_one(input logic [W-1:0] d, input int max_gap);
    int  gap;
    int  t;
    bit  rdy_seen;
    gap      = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    rdy_seen = 1'b0;
    repeat (gap) begin
      resp_valid = 1'b0;
      resp_data  = W'($urandom);
      if (rdy_seen) check("ready_hold", 32'(resp_ready), 32'd1);
      if (resp_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
    resp_valid = 1'b1;
    resp_data  = d;
    t = 0;
    while (!resp_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!resp_ready) begin
      check("hs_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
  endtask

  // Start a run, feed all responses and wait for done. cycles is the number
  // of clocks from the start-sampling edge to the edge where done rose.
  task automatic drive_run(input int max_gap, input bit inject_start, output int cycles);
    time t0;
    int  t;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = $time;
    check("run.busy",  32'(busy), 32'd1);
    check("run.ready", 32'(resp_ready), 32'd0);
    check("run.done",  32'(done), 32'd0);
    check("run.pass",  32'(pass), 32'd0);
    check("run.count", 32'(mismatch_count), 32'd0);
    check("run.ffi",   32'(first_fail_index), 32'((1 << IW) - 1));
    check("run.mask",  32'(detect_mask), 32'd0);
    for (int i = 0; i < NT; i++) begin
      send_one(resp[i], max_gap);
      if (inject_start && i == 0) begin
        resp_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
      end
    end
    resp_valid = 1'b0;
    t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("run.done_seen", 32'(done), 32'd1);
    cycles = int'(($time - t0) / PERIOD);
  endtask

  task automatic idle_valid_probe(input string tag, input int exp_count, input bit exp_done);
    resp_valid = 1'b1;
    resp_data  = 7'h7F;
    repeat (3) begin
      @(negedge clk);
      check({tag, ".ready"}, 32'(resp_ready), 32'd0);
    end
    resp_valid = 1'b0;
    @(negedge clk);
    check({tag, ".count"}, 32'(mismatch_count), 32'(exp_count));
    check({tag, ".done"},  32'(done), 32'(exp_done));
  endtask

  task automatic load_scenario(input bit faulty);
    rom[0] = 7'h00; rom[1] = 7'h7F; rom[2] = 7'h55; rom[3] = 7'h2A;
    if (faulty) begin
      resp[0] = 7'h00; resp[1] = 7'h7E; resp[2] = 7'h55; resp[3] = 7'h6A;
    end else begin
      for (int i = 0; i < NT; i++) resp[i] = rom[i];
    end
    model_run();
  endtask

  initial begin
    int cyc;
    rst_n      = 1'b0;
    start      = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    for (int i = 0; i < NT; i++) begin
      rom[i]  = '0;
      resp[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Valid while idle is ignored.
    idle_valid_probe("idle_valid", 0, 1'b0);

    // Clean run with valid held: 4 transfers, done 8 clocks after start.
    load_scenario(1'b0);
    drive_run(0, 1'b0, cyc);
    check("clean.cycles", 32'(cyc), 32'd8);
    check_stats("clean");

    // Two faulty vectors.
    load_scenario(1'b1);
    drive_run(0, 1'b0, cyc);
    check("fault.cycles", 32'(cyc), 32'd8);
    check("fault.count_const", 32'(mismatch_count), 32'd2);
    check("fault.mask_const",  32'(detect_mask), 32'h41);
    check_stats("fault");

    // Valid in DONE is ignored.
    idle_valid_probe("done_valid", m_count, 1'b1);

    // Same data with gaps between responses.
    drive_run(3, 1'b0, cyc);
    check_stats("gaps");

    // Start while busy ignored, then a restart from DONE gives the same result.
    drive_run(2, 1'b1, cyc);
    check_stats("busy_start");
    drive_run(2, 1'b0, cyc);
    check_stats("rerun");

    // Reset after two transfers, with start asserted alongside it.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_one(resp[0], 0);
    send_one(resp[1], 0);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_reset_values("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.idle", 32'(busy), 32'd0);
    load_scenario(1'b0);
    drive_run(1, 1'b0, cyc);
    check_stats("after_rst");

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NT; i++) begin
        rom[i]  = W'($urandom);
        resp[i] = ($urandom_range(0, 2) == 0) ? rom[i] ^ W'($urandom) : rom[i];
      end
      model_run();
      drive_run(3, ($urandom_range(0, 3) == 0), cyc);
      check_stats($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/response_checker.md
Name: response_checker

Overview:
Synthesizable golden-response comparator for the single-fault simulation flow. It is the receiving end of the vector-apply path. The driver side applies input vectors to a circuit under test, such as c432. This block then accepts the circuit's output vectors over a valid/ready handshake and compares each one against an expected vector read from a synchronous ROM. It reports mismatch statistics, the first failing vector index, and a per-output detection mask, for on-chip fault-detection experiments.

Parameters:
OUTPUT_WIDTH, 7, width of one response vector (c432 has 7 outputs).
NUMBER_OF_TESTS, 10000, number of vectors in one run.
INDEX_WIDTH, 14, width of vector indices and counters. Must satisfy 2^INDEX_WIDTH > NUMBER_OF_TESTS.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active low.
start  input  1  single-cycle pulse that begins a run.
resp_valid  input  1  resp_data holds a response vector.
resp_ready  output  1  checker accepts resp_data this cycle.
resp_data  input  OUTPUT_WIDTH  circuit response vector.
exp_addr  output  INDEX_WIDTH  expected-vector ROM address.
exp_data  input  OUTPUT_WIDTH  ROM data, valid 1 cycle after exp_addr.
busy  output  1  a run is in progress.
done  output  1  run complete; held until the next start or reset.
pass  output  1  run completed with zero mismatches; valid when done=1.
mismatch_count  output  INDEX_WIDTH  number of vectors that differed.
first_fail_index  output  INDEX_WIDTH  index of the first differing vector; all-ones if none.
first_fail_diff  output  OUTPUT_WIDTH  XOR of response and expected at first_fail_index.
detect_mask  output  OUTPUT_WIDTH  OR of all per-vector XOR differences (outputs ever observed wrong).

Behaviour:
- Clocking and reset: single clock domain, all state updates on rising clk. rst_n=0 sampled at an edge puts the block in IDLE, including mid-run.
- Reset values: resp_ready=0, busy=0, done=0, pass=0, exp_addr=0, mismatch_count=0, first_fail_index=all-ones, first_fail_diff=0, detect_mask=0, internal index=0.
- State IDLE:
  - start=1 → FETCH. Index and all statistics are cleared as at reset.
  - busy=1 from the cycle after start.
- State FETCH:
  - exp_addr=index.
  - Next cycle, exp_data is registered into an expected register → COMPARE.
- State COMPARE:
  - resp_ready=1.
  - Transfer occurs on a cycle with resp_valid=1 and resp_ready=1. Then:
    - diff = resp_data XOR expected.
    - If diff≠0: mismatch_count increments, saturating at 2^INDEX_WIDTH-1.
    - If diff≠0 and this is the first mismatch of the run: first_fail_index and first_fail_diff are captured.
    - detect_mask |= diff.
  - After a transfer:
    - If index = NUMBER_OF_TESTS-1 → DONE.
    - Otherwise index increments → FETCH.
  - resp_valid=0: stay in COMPARE, no state change.
- State DONE:
  - busy=0, done=1.
  - pass=1 iff mismatch_count=0; pass is registered on entry to DONE.
  - start=1 → clears done, pass and statistics → FETCH.
- Throughput: at most one vector per 2 cycles. Latency from start to first resp_ready is 2 cycles.
- Handshake rules:
  - resp_ready is 0 outside COMPARE.
  - resp_valid outside COMPARE is ignored and never counted.
  - resp_data is sampled only on the transfer cycle.
- start while busy is ignored.
- start and rst_n=0 in the same cycle: reset wins.
- Statistics outputs are registered and update the cycle after the transfer. The final values are stable when done rises.

Test Plan:
1. Reset with NUMBER_OF_TESTS=4, ROM={0x00,0x7F,0x55,0x2A}, responses identical, resp_valid held 1 → 4 transfers in 8 cycles after start; done=1, pass=1, mismatch_count=0, first_fail_index=0x3FFF, detect_mask=0.
2. Same ROM, responses {0x00,0x7E,0x55,0x6A} → mismatch_count=2, first_fail_index=1, first_fail_diff=0x01, detect_mask=0x41, pass=0.
3. resp_valid toggled 1,0,0,1 with random gaps → resp_ready stays high while waiting; no duplicate or missed compare; counts match the scenario 2 results.
4. rst_n=0 asserted after 2 transfers → next cycle all outputs at reset values. A new start then runs cleanly to pass=1.
5. start pulsed while busy, and again in DONE → first pulse ignored; second clears done and statistics and re-runs; results identical to the prior run.
6. resp_valid=1 with resp_data=0x7F while IDLE and DONE → no transfer, mismatch_count unchanged.
